win_checker: RTL and testbench
==============================

Name: win_checker

Overview:
- Reads the 42-cell gameboard produced by the column-selection logic and determines the game result.
- Inputs are the occupancy vector (1 = cell filled) and the owner vector (0 = Player1, 1 = Player2).
- On a start pulse it snapshots both vectors and scans every (cell, direction) candidate, one per clock, for CONNECT same-player cells in a line.
- It reports winner, draw or no-result, plus a mask of the winning cells for display highlighting. The game FSM issues start after each token placement.

Parameters:
- ROWS, 6, board rows; row 0 = bottom (first filled)
- COLS, 7, board columns
- CONNECT, 4, run length required to win; only the defaults are verified

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to evaluate the board; ignored while busy
- in_gameboard  in  42  occupancy; bit index = row*7 + col
- in_players_cells  in  42  owner per cell; 0 = P1, 1 = P2; meaningless where occupancy = 0
- busy  out  1  high while scanning
- done  out  1  one-cycle pulse when the result is valid
- result  out  2  00 none, 01 P1 wins, 10 P2 wins, 11 draw (board full, no win)
- win_mask  out  42  1 on the CONNECT winning cells; zero otherwise

Behaviour:
- Reset (sync, active-high):
  - FSM goes to IDLE.
  - busy = 0, done = 0, result = 00, win_mask = 0, candidate counter = 0.
  - Reset has priority over start and aborts a scan in progress; no done is produced.
- FSM states:
  - IDLE: on start, latch both input vectors into snapshot registers, clear result and win_mask, set cell = 0 and dir = 0, go to SCAN.
  - SCAN: busy = 1. Evaluate one candidate per cycle.
    - Candidate order is cell 0..41 outer, dir 0..3 inner; k = cell*4 + dir.
    - Directions: 0 = +col, 1 = +row, 2 = +row+col, 3 = +row-col.
    - Candidate is a hit when all CONNECT cells are in bounds, all are occupied in the snapshot, and all have the same owner bit.
    - Bounds are checked on row and col separately. No wrap across row edges: cells 4, 5, 6, 7 are never a horizontal line.
    - On hit: result = owner + 1, win_mask = the candidate's cells, go to DONE.
    - On last candidate (k = 167) with no hit: result = 11 if the snapshot occupancy is all ones, else 00; go to DONE.
  - DONE: done = 1 and busy = 0 for exactly one cycle, then IDLE. result and win_mask hold until the next accepted start or reset.
- Latency, with start sampled at edge N:
  - SCAN occupies cycles N+1 … ; candidate k is evaluated in cycle N+1+k.
  - Hit at k gives done high in cycle N+k+2.
  - No hit gives done high in cycle N+169.
- Only the first hit in scan order is reported. Simultaneous wins are not flagged.
- Input changes after start have no effect; the snapshot is used for the whole scan.
- start during SCAN or DONE is ignored, not queued.
- Occupancy = 0 cells never contribute, whatever their owner bit.

Decomposition:
- connect4_pkg:
  - constants ROWS, COLS, NCELLS = 42, CONNECT
  - result encodings RES_NONE, RES_P1, RES_P2, RES_DRAW
  - direction constants DIR_H, DIR_V, DIR_DR, DIR_DL
  - FSM state encoding
  - index function row*COLS + col
- Sub-module line_check (combinational):
  - Inputs: snapshot vectors, cell index, dir.
  - Outputs: hit, owner, 42-bit mask.
  - win_checker holds the FSM, counters and output registers.

Test Plan:
- Empty board, start at N -> busy for 168 cycles, done in cycle N+169, result 00, win_mask 0.
- P1 on cells 0, 1, 2, 3 (owner 0) -> hit at k = 0, done at N+2, result 01, win_mask = 0x00000000F.
- P2 on cells 6, 13, 20, 27 (column 6, vertical) -> hit at k = 25, done at N+27, result 10, win_mask bits 6, 13, 20, 27.
- P1 on cells 3, 9, 15, 21 (dir 3) -> hit at k = 15, done at N+17, result 01. Separately, P1 on cells 4, 5, 6, 7 (row wrap) -> done at N+169, result 00.
- Full board, owner(r, c) = ((c>>1) ^ r) & 1 -> no line, done at N+169, result 11.
- Reset asserted in cycle N+50 of a scan -> next cycle busy = 0, done stays 0, outputs cleared. A start pulse issued while busy -> ignored, done pulses exactly once for the original start.

Source files
------------

// File: rtl/connect4_pkg.sv
// Shared board geometry, result/direction encodings and FSM states for the
// connect-four win checker.
package connect4_pkg;

    localparam int ROWS    = 6;
    localparam int COLS    = 7;
    localparam int NCELLS  = ROWS * COLS;
    localparam int CONNECT = 4;

    localparam logic [1:0] RES_NONE = 2'b00;
    localparam logic [1:0] RES_P1   = 2'b01;
    localparam logic [1:0] RES_P2   = 2'b10;
    localparam logic [1:0] RES_DRAW = 2'b11;

    localparam logic [1:0] DIR_H  = 2'd0;
    localparam logic [1:0] DIR_V  = 2'd1;
    localparam logic [1:0] DIR_DR = 2'd2;
    localparam logic [1:0] DIR_DL = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic [5:0] cellIndex(input int row, input int col);
        return 6'(row * COLS + col);
    endfunction

endpackage

// File: rtl/win_checker_if.sv
// Request/result bundle between the game FSM and the win checker.
interface win_checker_if;

    logic        start;
    logic [41:0] in_gameboard;
    logic [41:0] in_players_cells;
    logic        busy;
    logic        done;
    logic [1:0]  result;
    logic [41:0] win_mask;

    modport master (
        output start, in_gameboard, in_players_cells,
        input  busy, done, result, win_mask
    );

    modport slave (
        input  start, in_gameboard, in_players_cells,
        output busy, done, result, win_mask
    );

endinterface

// File: rtl/win_checker_line_check.sv
// Combinational test of one (cell, direction) candidate: reports whether all
// CONNECT cells are on the board, occupied and owned by the same player.
module line_check
    import connect4_pkg::*;
(
    input  logic [41:0] i_occ,
    input  logic [41:0] i_own,
    input  logic [5:0]  i_cell,
    input  logic [1:0]  i_dir,
    output logic        o_hit,
    output logic        o_owner,
    output logic [41:0] o_mask
);

    logic        w_hit;
    logic        w_own0;
    logic [41:0] w_mask;
    logic [5:0]  w_idx;
    int          w_row;
    int          w_col;
    int          w_dr;
    int          w_dc;
    int          w_r;
    int          w_c;

    // Row and column are bounds-checked separately so lines never wrap.
    always_comb begin
        w_hit  = 1'b1;
        w_mask = '0;
        w_idx  = '0;
        w_r    = 0;
        w_c    = 0;
        w_row  = int'(i_cell) / COLS;
        w_col  = int'(i_cell) % COLS;
        w_own0 = i_own[i_cell];
        case (i_dir)
            DIR_H:   begin w_dr = 0; w_dc = 1;  end
            DIR_V:   begin w_dr = 1; w_dc = 0;  end
            DIR_DR:  begin w_dr = 1; w_dc = 1;  end
            default: begin w_dr = 1; w_dc = -1; end
        endcase
        for (int i = 0; i < CONNECT; i++) begin
            w_r = w_row + w_dr * i;
            w_c = w_col + w_dc * i;
            if (w_r < 0 || w_r >= ROWS || w_c < 0 || w_c >= COLS) begin
                w_hit = 1'b0;
            end else begin
                w_idx = cellIndex(w_r, w_c);
                if (!i_occ[w_idx] || (i_own[w_idx] != w_own0)) begin
                    w_hit = 1'b0;
                end
                w_mask[w_idx] = 1'b1;
            end
        end
    end

    assign o_hit   = w_hit;
    assign o_owner = w_own0;
    assign o_mask  = w_hit ? w_mask : '0;

endmodule

// File: rtl/win_checker.sv
// Snapshots the board on start and walks all 168 (cell, direction) candidates,
// one per clock, reporting the first winning line, a draw, or no result.
module win_checker
    import connect4_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    win_checker_if.slave bus
);

    localparam logic [5:0] LAST_CELL = 6'(NCELLS - 1);

    state_t      r_state;
    logic [41:0] r_occ;
    logic [41:0] r_own;
    logic [5:0]  r_cell;
    logic [1:0]  r_dir;
    logic [1:0]  r_result;
    logic [41:0] r_winMask;

    state_t      w_stateNext;
    logic [41:0] w_occNext;
    logic [41:0] w_ownNext;
    logic [5:0]  w_cellNext;
    logic [1:0]  w_dirNext;
    logic [1:0]  w_resultNext;
    logic [41:0] w_winMaskNext;

    logic        w_hit;
    logic        w_owner;
    logic [41:0] w_lineMask;
    logic        w_lastCand;

    line_check u_lineCheck (
        .i_occ   (r_occ),
        .i_own   (r_own),
        .i_cell  (r_cell),
        .i_dir   (r_dir),
        .o_hit   (w_hit),
        .o_owner (w_owner),
        .o_mask  (w_lineMask)
    );

    assign w_lastCand = (r_cell == LAST_CELL) && (r_dir == DIR_DL);

    always_comb begin
        w_stateNext   = r_state;
        w_occNext     = r_occ;
        w_ownNext     = r_own;
        w_cellNext    = r_cell;
        w_dirNext     = r_dir;
        w_resultNext  = r_result;
        w_winMaskNext = r_winMask;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_occNext     = bus.in_gameboard;
                    w_ownNext     = bus.in_players_cells;
                    w_cellNext    = '0;
                    w_dirNext     = '0;
                    w_resultNext  = RES_NONE;
                    w_winMaskNext = '0;
                    w_stateNext   = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (w_hit) begin
                    w_resultNext  = w_owner ? RES_P2 : RES_P1;
                    w_winMaskNext = w_lineMask;
                    w_stateNext   = ST_DONE;
                end else if (w_lastCand) begin
                    w_resultNext  = (&r_occ) ? RES_DRAW : RES_NONE;
                    w_stateNext   = ST_DONE;
                end else begin
                    // Direction is the inner loop; its 2-bit wrap advances the cell.
                    w_dirNext = r_dir + 2'd1;
                    if (r_dir == DIR_DL) begin
                        w_cellNext = r_cell + 6'd1;
                    end
                end
            end
            ST_DONE: begin
                w_stateNext = ST_IDLE;
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_occ     <= '0;
            r_own     <= '0;
            r_cell    <= '0;
            r_dir     <= '0;
            r_result  <= RES_NONE;
            r_winMask <= '0;
        end else begin
            r_state   <= w_stateNext;
            r_occ     <= w_occNext;
            r_own     <= w_ownNext;
            r_cell    <= w_cellNext;
            r_dir     <= w_dirNext;
            r_result  <= w_resultNext;
            r_winMask <= w_winMaskNext;
        end
    end

    assign bus.busy     = (r_state == ST_SCAN);
    assign bus.done     = (r_state == ST_DONE);
    assign bus.result   = r_result;
    assign bus.win_mask = r_winMask;

endmodule

// File: tb/tb_win_checker.sv
// Directed scoreboard bench for win_checker: each start pushes the expected
// result, mask and latency, which are popped and compared when done pulses.
module tb_win_checker;

    typedef struct {
        logic [1:0]  res;
        logic [41:0] mask;
        int          lat;
    } exp_t;

    logic clk;
    logic reset;
    int   passCount;
    int   totalCount;
    exp_t sbQ[$];

    win_checker_if bus ();

    win_checker dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        totalCount++;
        assert (obs === exp) passCount++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Drives start at a negedge; returns at the negedge following the sampling edge.
    task automatic applyStimulus(input logic [41:0] occ, input logic [41:0] own,
                                 input logic [1:0] expRes, input logic [41:0] expMask,
                                 input int expLat, input logic doPush);
        exp_t e;
        e.res  = expRes;
        e.mask = expMask;
        e.lat  = expLat;
        if (doPush) sbQ.push_back(e);
        @(negedge clk);
        bus.in_gameboard     = occ;
        bus.in_players_cells = own;
        bus.start            = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Waits (bounded) for done, optionally altering inputs at lat == pokeAt.
    task automatic runToDone(input string tag, input int pokeAt, input logic [41:0] pokeOcc,
                             input logic [41:0] pokeOwn, input logic pokeStart);
        int   lat;
        int   busyCnt;
        exp_t e;
        lat     = 0;
        busyCnt = 0;
        while (!bus.done && lat < 400) begin
            if (bus.busy) busyCnt++;
            if (lat == pokeAt) begin
                bus.in_gameboard     = pokeOcc;
                bus.in_players_cells = pokeOwn;
                bus.start            = pokeStart;
            end
            if (lat == pokeAt + 1) bus.start = 1'b0;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (!bus.done) begin
            totalCount++;
            $error("FAIL %s_timeout: observed no done expected done within 400 cycles", tag);
        end else if (sbQ.size() == 0) begin
            totalCount++;
            $error("FAIL %s_sb: observed unexpected done expected none", tag);
        end else begin
            e = sbQ.pop_front();
            checkOutput({tag, "_result"}, 64'(bus.result), 64'(e.res));
            checkOutput({tag, "_mask"}, 64'(bus.win_mask), 64'(e.mask));
            checkOutput({tag, "_latency"}, 64'(lat), 64'(e.lat));
            checkOutput({tag, "_busycycles"}, 64'(busyCnt), 64'(e.lat));
            checkOutput({tag, "_busyAtDone"}, 64'(bus.busy), 64'(0));
            @(posedge clk);
            @(negedge clk);
            checkOutput({tag, "_donePulse"}, 64'(bus.done), 64'(0));
            checkOutput({tag, "_resultHold"}, 64'(bus.result), 64'(e.res));
        end
    endtask

    initial begin
        logic [41:0] occ;
        logic [41:0] own;
        logic [41:0] m;
        logic [41:0] allOnes;
        int          extraDone;

        passCount  = 0;
        totalCount = 0;
        allOnes    = '1;
        bus.start            = 1'b0;
        bus.in_gameboard     = '0;
        bus.in_players_cells = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_busy", 64'(bus.busy), 64'(0));
        checkOutput("rst_done", 64'(bus.done), 64'(0));
        checkOutput("rst_result", 64'(bus.result), 64'(0));
        checkOutput("rst_mask", 64'(bus.win_mask), 64'(0));
        reset = 1'b0;

        // Empty board: full scan, no result.
        applyStimulus('0, '1, 2'b00, '0, 168, 1'b1);
        runToDone("empty", -10, '0, '0, 1'b0);

        // P1 bottom row cells 0..3: first candidate.
        occ = 42'h00000000F;
        applyStimulus(occ, '0, 2'b01, 42'h00000000F, 1, 1'b1);
        runToDone("p1_horiz", -10, '0, '0, 1'b0);

        // P2 column 6 vertical; inputs cleared mid-scan must not matter.
        m = '0;
        m[6] = 1'b1; m[13] = 1'b1; m[20] = 1'b1; m[27] = 1'b1;
        applyStimulus(m, m, 2'b10, m, 26, 1'b1);
        runToDone("p2_vert", 3, '0, '0, 1'b0);

        // P1 anti-diagonal 3, 9, 15, 21.
        m = '0;
        m[3] = 1'b1; m[9] = 1'b1; m[15] = 1'b1; m[21] = 1'b1;
        applyStimulus(m, '0, 2'b01, m, 16, 1'b1);
        runToDone("p1_diagL", -10, '0, '0, 1'b0);

        // Cells 4..7 straddle a row edge and must not count.
        m = '0;
        m[4] = 1'b1; m[5] = 1'b1; m[6] = 1'b1; m[7] = 1'b1;
        applyStimulus(m, '0, 2'b00, '0, 168, 1'b1);
        runToDone("rowwrap", -10, '0, '0, 1'b0);

        // Unoccupied cells with owner 1 form no line either.
        applyStimulus(42'h00000000E, 42'h00000000F, 2'b00, '0, 168, 1'b1);
        runToDone("unocc", -10, '0, '0, 1'b0);

        // Full board with no line -> draw; a start mid-scan must be ignored.
        own = '0;
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 7; c++)
                own[r*7 + c] = 1'(((c >> 1) ^ r) & 1);
        applyStimulus(allOnes, own, 2'b11, '0, 168, 1'b1);
        runToDone("draw", 10, 42'h00000000F, '0, 1'b1);
        extraDone = 0;
        repeat (20) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.done) extraDone++;
        end
        checkOutput("ignoredStart_noExtraDone", 64'(extraDone), 64'(0));
        checkOutput("ignoredStart_sbEmpty", 64'(sbQ.size()), 64'(0));

        // Reset in cycle N+50 of a scan aborts without done.
        m = '0;
        m[35] = 1'b1; m[36] = 1'b1; m[37] = 1'b1; m[38] = 1'b1;
        applyStimulus(m, '0, 2'b00, '0, 0, 1'b0);
        repeat (49) begin
            @(posedge clk);
            @(negedge clk);
        end
        checkOutput("abort_busyBefore", 64'(bus.busy), 64'(1));
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("abort_busy", 64'(bus.busy), 64'(0));
        checkOutput("abort_done", 64'(bus.done), 64'(0));
        checkOutput("abort_result", 64'(bus.result), 64'(0));
        checkOutput("abort_mask", 64'(bus.win_mask), 64'(0));
        reset = 1'b0;
        extraDone = 0;
        repeat (200) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.done || bus.busy) extraDone++;
        end
        checkOutput("abort_quiet", 64'(extraDone), 64'(0));

        // Checker is usable again after the abort: P1 row 5 win.
        applyStimulus(m, '0, 2'b01, m, 141, 1'b1);
        runToDone("p1_topRow", -10, '0, '0, 1'b0);

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
